// File: rtl/rifl_pkg.sv
// Shared types for the RIFL receive path.
// Holds the width-converter state encoding and error counter width.
package rifl_pkg;

   typedef enum logic {
      SYNC  = 1'b0,
      ACCUM = 1'b1
   } dwc_state_e;

   localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/rx_dwidth_conv.sv
// RX width converter: packs MSB-lane-first narrow beats into wide words.
// Optional saturating error counter under RIFL_RX_DWC_ERR_CNT_EN.
module rx_dwidth_conv
   import rifl_pkg::*;
#(
   parameter int DWIDTH_IN  = 64,
   parameter int DWIDTH_OUT = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DWIDTH_IN-1:0]  din,
   input  logic                  din_vld,
   input  logic                  sof_in,
   output logic [DWIDTH_OUT-1:0] dout,
   output logic                  dout_vld,
   output logic                  sof_err,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   localparam int RATIO     = DWIDTH_OUT / DWIDTH_IN;
   localparam int CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RATIO - 1);

   dwc_state_e            state, state_n;
   logic [CNT_WIDTH-1:0]  cnt, cnt_n;
   logic [DWIDTH_OUT-1:0] acc, acc_n;
   logic [DWIDTH_OUT-1:0] word, lane;
   logic                  start, append, load, err;

   // Next-state decode: alignment, lane append, completion and framing errors
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      acc_n   = acc;
      start   = 1'b0;
      append  = 1'b0;
      load    = 1'b0;
      err     = 1'b0;
      lane    = DWIDTH_OUT'(din);
      word    = (acc << DWIDTH_IN) | lane;
      if (din_vld) begin
         unique case (state)
            SYNC: begin
               if (sof_in) begin
                  start = 1'b1;
               end else if (RATIO == 1) begin
                  err = 1'b1;
               end
            end
            ACCUM: begin
               if (sof_in) begin
                  start = 1'b1;
                  err   = (cnt != '0);
               end else if (cnt == '0) begin
                  err     = 1'b1;
                  state_n = SYNC;
               end else begin
                  append = 1'b1;
               end
            end
         endcase
      end
      if (start) begin
         state_n = ACCUM;
         if (RATIO == 1) begin
            load  = 1'b1;
            word  = lane;
            cnt_n = '0;
         end else begin
            acc_n = lane;
            cnt_n = CNT_WIDTH'(1);
         end
      end
      if (append) begin
         acc_n = word;
         if (cnt == LAST) begin
            load  = 1'b1;
            cnt_n = '0;
         end else begin
            cnt_n = cnt + CNT_WIDTH'(1);
         end
      end
   end

   // State, accumulator and registered output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SYNC;
         cnt      <= '0;
         acc      <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         sof_err  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         acc      <= acc_n;
         dout_vld <= load;
         sof_err  <= err;
         if (load) begin
            dout <= word;
         end
      end
   end

`ifdef RIFL_RX_DWC_ERR_CNT_EN
   // Saturating count of framing errors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_dwidth_conv.sv
// Bench for rx_dwidth_conv: lane-queue model plus directed frames.
// Checks every cycle and pins the model with literal expectations.
module tb_rx_dwidth_conv;

   logic         clk;
   logic         rst_n;
   logic [63:0]  din;
   logic         din_vld;
   logic         sof_in;
   logic [255:0] dout;
   logic         dout_vld;
   logic         sof_err;
   logic [15:0]  err_cnt;

   int checks = 0;
   int passed = 0;
   int n_vld  = 0;
   int n_err  = 0;

   localparam logic [63:0] A = 64'hA0A1_A2A3_A4A5_A6A7;
   localparam logic [63:0] B = 64'hB0B1_B2B3_B4B5_B6B7;
   localparam logic [63:0] C = 64'hC0C1_C2C3_C4C5_C6C7;
   localparam logic [63:0] D = 64'hD0D1_D2D3_D4D5_D6D7;
   localparam logic [63:0] E = 64'hE0E1_E2E3_E4E5_E6E7;
   localparam logic [63:0] F = 64'hF0F1_F2F3_F4F5_F6F7;
   localparam logic [63:0] G = 64'h1011_1213_1415_1617;
   localparam logic [63:0] H = 64'h2021_2223_2425_2627;
   localparam logic [63:0] X = 64'h5555_6666_7777_8888;

`ifdef RIFL_RX_DWC_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   rx_dwidth_conv #(
      .DWIDTH_IN  (64),
      .DWIDTH_OUT (256)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_vld  (din_vld),
      .sof_in   (sof_in),
      .dout     (dout),
      .dout_vld (dout_vld),
      .sof_err  (sof_err),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a frame is a list of lanes opened by SOF; four lanes make a word
   logic [63:0]  lanes[$];
   bit           m_sync;
   logic [255:0] m_dout;
   logic         m_vld;
   logic         m_err;
   int           m_ecnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes.delete();
         m_sync = 1'b1;
         m_dout = '0;
         m_vld  = 1'b0;
         m_err  = 1'b0;
         m_ecnt = 0;
      end else begin
         m_vld = 1'b0;
         m_err = 1'b0;
         if (din_vld) begin
            if (sof_in) begin
               if (lanes.size() != 0) m_err = 1'b1;
               lanes.delete();
               lanes.push_back(din);
               m_sync = 1'b0;
            end else if (!m_sync) begin
               if (lanes.size() == 0) begin
                  m_err  = 1'b1;
                  m_sync = 1'b1;
               end else begin
                  lanes.push_back(din);
               end
            end
            if (lanes.size() == 4) begin
               m_dout = {lanes[0], lanes[1], lanes[2], lanes[3]};
               m_vld  = 1'b1;
               lanes.delete();
            end
         end
         if (m_err && m_ecnt < 65535) m_ecnt++;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("dout", dout, m_dout);
         chk("dout_vld", 256'(dout_vld), 256'(m_vld));
         chk("sof_err", 256'(sof_err), 256'(m_err));
         chk("err_cnt", 256'(err_cnt), CNT_EN ? 256'(m_ecnt) : 256'(0));
         if (dout_vld) n_vld++;
         if (sof_err) n_err++;
      end
   end

   task automatic beat(input logic [63:0] d, input logic s);
      din     = d;
      sof_in  = s;
      din_vld = 1'b1;
      @(posedge clk);
      #1;
      din_vld = 1'b0;
      sof_in  = 1'b0;
      din     = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int v0, e0;

   initial begin
      rst_n   = 1'b0;
      din     = '0;
      din_vld = 1'b0;
      sof_in  = 1'b0;
      idle(2);
      chk("rst_dout", dout, 256'd0);
      chk("rst_vld", 256'(dout_vld), 256'd0);
      chk("rst_err", 256'(sof_err), 256'd0);
      chk("rst_cnt", 256'(err_cnt), 256'd0);
      rst_n = 1'b1;
      idle(1);

      // startup misalignment
      v0 = n_vld; e0 = n_err;
      beat(X, 1'b0); beat(X, 1'b0); beat(X, 1'b0);
      beat(E, 1'b1); beat(F, 1'b0); beat(G, 1'b0); beat(H, 1'b0);
      chk("misalign_vld_now", 256'(dout_vld), 256'd1);
      idle(2);
      chk("misalign_dout", dout, {E, F, G, H});
      chk("misalign_npulse", 256'(n_vld - v0), 256'd1);
      chk("misalign_nerr", 256'(n_err - e0), 256'd0);

      // aligned back-to-back frame
      v0 = n_vld;
      beat(A, 1'b1); beat(B, 1'b0); beat(C, 1'b0); beat(D, 1'b0);
      chk("aligned_vld_now", 256'(dout_vld), 256'd1);
      idle(3);
      chk("aligned_dout", dout, {A, B, C, D});
      chk("aligned_msb", 256'(dout[255:192]), 256'(A));
      chk("aligned_npulse", 256'(n_vld - v0), 256'd1);

      // gaps between beats
      v0 = n_vld; e0 = n_err;
      beat(D, 1'b1); idle(1);
      beat(C, 1'b0); idle(2);
      beat(B, 1'b0); idle(1);
      chk("gap_no_early", 256'(n_vld - v0), 256'd0);
      beat(A, 1'b0); idle(2);
      chk("gap_dout", dout, {D, C, B, A});
      chk("gap_npulse", 256'(n_vld - v0), 256'd1);
      chk("gap_nerr", 256'(n_err - e0), 256'd0);

      // early SOF
      v0 = n_vld; e0 = n_err;
      beat(A, 1'b1); beat(B, 1'b0);
      beat(E, 1'b1);
      chk("early_err_now", 256'(sof_err), 256'd1);
      beat(F, 1'b0); beat(G, 1'b0); beat(H, 1'b0);
      idle(2);
      chk("early_dout", dout, {E, F, G, H});
      chk("early_npulse", 256'(n_vld - v0), 256'd1);
      chk("early_nerr", 256'(n_err - e0), 256'd1);

      // missing SOF after a full frame, then recovery
      v0 = n_vld; e0 = n_err;
      beat(B, 1'b1); beat(C, 1'b0); beat(D, 1'b0); beat(A, 1'b0);
      beat(X, 1'b0);
      chk("missing_err_now", 256'(sof_err), 256'd1);
      beat(X, 1'b0);
      beat(H, 1'b1); beat(G, 1'b0); beat(F, 1'b0); beat(E, 1'b0);
      idle(2);
      chk("missing_dout", dout, {H, G, F, E});
      chk("missing_npulse", 256'(n_vld - v0), 256'd2);
      chk("missing_nerr", 256'(n_err - e0), 256'd1);
      chk("missing_errcnt", 256'(err_cnt), CNT_EN ? 256'd2 : 256'd0);

      // reset mid-word
      beat(A, 1'b1); beat(B, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_dout", dout, 256'd0);
      chk("midrst_vld", 256'(dout_vld), 256'd0);
      chk("midrst_cnt", 256'(err_cnt), 256'd0);
      idle(2);
      rst_n = 1'b1;
      v0 = n_vld; e0 = n_err;
      beat(C, 1'b0);
      beat(G, 1'b1); beat(E, 1'b0); beat(H, 1'b0); beat(F, 1'b0);
      idle(2);
      chk("midrst_new_dout", dout, {G, E, H, F});
      chk("midrst_npulse", 256'(n_vld - v0), 256'd1);
      chk("midrst_nerr", 256'(n_err - e0), 256'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
